btn_debounce_pulse: RTL and testbench

Conditions a raw pushbutton (e.g. btnC) before it reaches the flip-flop demo stage. The block synchronises the button, filters bounce with a stability counter, and produces three outputs: a clean level, a one-cycle press pulse and a one-cycle release pulse. It also keeps an 8-bit press counter. The downstream D/JK/T flip-flop stage uses the clean level or press pulse as its clock or enable in place of the bouncing raw button.

---
 rtl/btn_debounce_pulse_if.sv | 24 ++
 rtl/btn_debounce_pulse.sv | 144 ++++++++++++++
 tb/tb_btn_debounce_pulse.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/btn_debounce_pulse_if.sv
// Button conditioner signal bundle: raw button in, debounced level, strobes and press count out.
interface btn_debounce_pulse_if;
  logic       btn_in;
  logic       btn_level;
  logic       press_pulse;
  logic       release_pulse;
  logic [7:0] press_count;

  modport master (
    output btn_in,
    input  btn_level,
    input  press_pulse,
    input  release_pulse,
    input  press_count
  );

  modport slave (
    input  btn_in,
    output btn_level,
    output press_pulse,
    output release_pulse,
    output press_count
  );
endinterface

// File: rtl/btn_debounce_pulse.sv
// Pushbutton synchroniser + stability-counter debouncer with press/release strobes and a wrapping press counter.
// Optional auto-repeat of press_pulse while held is built only when BTN_AUTO_REPEAT_EN is defined.
module btn_debounce_pulse #(
  parameter int STABLE_CYCLES = 1000000,
  parameter int SYNC_STAGES   = 2,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input logic                 clk,
  input logic                 rst,
  btn_debounce_pulse_if.slave bus
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  localparam logic [1:0] IDLE        = 2'd0;
  localparam logic [1:0] ARM_PRESS   = 2'd1;
  localparam logic [1:0] HELD        = 2'd2;
  localparam logic [1:0] ARM_RELEASE = 2'd3;

  if (STABLE_CYCLES < 2 || SYNC_STAGES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
    $error("btn_debounce_pulse: parameter out of range");
  end

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   s;
  logic [1:0]             state_p1;
  logic [CNT_W-1:0]       cnt_p1;
  logic                   level_p1;
  logic                   press_p1;
  logic                   release_p1;
  logic [7:0]             count_p1;

`ifdef BTN_AUTO_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] REP_ONE    = REP_W'(1);
  localparam logic [REP_W-1:0] REP_DELAY  = REP_W'(REPEAT_DELAY);
  localparam logic [REP_W-1:0] REP_PERIOD = REP_W'(REPEAT_PERIOD);

  logic [REP_W-1:0] rep_cnt_p1;
  logic             rep_phase_p1;
  logic [REP_W-1:0] rep_target;

  // rep_cnt counts cycles since the last press strobe; phase selects delay vs period
  assign rep_target = rep_phase_p1 ? REP_PERIOD : REP_DELAY;
`endif

  // ---- stage p0: metastability synchroniser
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_p0 <= '0;
    else     sync_p0 <= {sync_p0[SYNC_STAGES-2:0], bus.btn_in};
  end

  assign s = sync_p0[SYNC_STAGES-1];

  // ---- stage p1: debounce FSM and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p1     <= IDLE;
      cnt_p1       <= '0;
      level_p1     <= 1'b0;
      press_p1     <= 1'b0;
      release_p1   <= 1'b0;
      count_p1     <= 8'd0;
`ifdef BTN_AUTO_REPEAT_EN
      rep_cnt_p1   <= '0;
      rep_phase_p1 <= 1'b0;
`endif
    end else begin
      press_p1   <= 1'b0;
      release_p1 <= 1'b0;
      case (state_p1)
        IDLE: begin
          if (s) begin
            state_p1 <= ARM_PRESS;
            cnt_p1   <= CNT_ONE;
          end
        end
        ARM_PRESS: begin
          if (!s) begin
            state_p1 <= IDLE;
            cnt_p1   <= '0;
          end else if (cnt_p1 == CNT_LAST) begin
            state_p1 <= HELD;
            cnt_p1   <= '0;
            level_p1 <= 1'b1;
            press_p1 <= 1'b1;
            count_p1 <= count_p1 + 8'd1;
`ifdef BTN_AUTO_REPEAT_EN
            rep_cnt_p1   <= REP_ONE;
            rep_phase_p1 <= 1'b0;
`endif
          end else begin
            cnt_p1 <= cnt_p1 + CNT_ONE;
          end
        end
        HELD: begin
          if (!s) begin
            state_p1 <= ARM_RELEASE;
            cnt_p1   <= CNT_ONE;
`ifdef BTN_AUTO_REPEAT_EN
            rep_cnt_p1   <= '0;
            rep_phase_p1 <= 1'b0;
          end else if (rep_cnt_p1 == rep_target) begin
            press_p1     <= 1'b1;
            count_p1     <= count_p1 + 8'd1;
            rep_cnt_p1   <= REP_ONE;
            rep_phase_p1 <= 1'b1;
          end else begin
            rep_cnt_p1 <= rep_cnt_p1 + REP_ONE;
`endif
          end
        end
        default: begin
          if (s) begin
            // release bounce rejected; auto-repeat restarts from the initial delay
            state_p1 <= HELD;
            cnt_p1   <= '0;
`ifdef BTN_AUTO_REPEAT_EN
            rep_cnt_p1   <= REP_ONE;
            rep_phase_p1 <= 1'b0;
`endif
          end else if (cnt_p1 == CNT_LAST) begin
            state_p1   <= IDLE;
            cnt_p1     <= '0;
            level_p1   <= 1'b0;
            release_p1 <= 1'b1;
          end else begin
            cnt_p1 <= cnt_p1 + CNT_ONE;
          end
        end
      endcase
    end
  end

  assign bus.btn_level     = level_p1;
  assign bus.press_pulse   = press_p1;
  assign bus.release_pulse = release_p1;
  assign bus.press_count   = count_p1;

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Scoreboard bench for btn_debounce_pulse: stimulus queues expected strobes, a negedge monitor checks them.
module tb_btn_debounce_pulse;

  localparam int STABLE = 4;
  localparam int SYNC   = 2;
  localparam int LAT    = STABLE + SYNC;

  logic clk;
  logic rst;
  int   cyc;
  int   n_cmp;
  int   n_bad;
  int   press_seen;
  int   exp_cnt;

  typedef struct {
    bit rel;
    int cyc;
    int cnt;
    bit lvl;
  } ev_t;

  ev_t exp_q[$];

  btn_debounce_pulse_if bus ();

  btn_debounce_pulse #(
    .STABLE_CYCLES (STABLE),
    .SYNC_STAGES   (SYNC),
    .REPEAT_DELAY  (10),
    .REPEAT_PERIOD (5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input bit rel, input int c, input int cnt, input bit lvl);
    ev_t e;
    e.rel = rel;
    e.cyc = c;
    e.cnt = cnt & 255;
    e.lvl = lvl;
    exp_q.push_back(e);
  endtask

  // one clean press then a clean release, both held for the full debounce window
  task automatic do_press();
    int t;
    t = cyc;
    bus.btn_in = 1'b1;
    exp_cnt = (exp_cnt + 1) & 255;
    push(1'b0, t + LAT, exp_cnt, 1'b1);
    wait_to(t + LAT);
    bus.btn_in = 1'b0;
    push(1'b1, t + 2 * LAT, exp_cnt, 1'b0);
    wait_to(t + 2 * LAT);
  endtask

  always @(negedge clk) begin
    if (!rst && (bus.press_pulse || bus.release_pulse)) begin
      ev_t e;
      if (bus.press_pulse) press_seen++;
      if (bus.press_pulse && bus.release_pulse)
        chk("both_pulses", 1, 0);
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", int'(bus.release_pulse) * 2 + int'(bus.press_pulse), 0);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_kind_rel", int'(bus.release_pulse), int'(e.rel));
        chk("pulse_cycle", cyc, e.cyc);
        chk("pulse_count", int'(bus.press_count), e.cnt);
        chk("pulse_level", int'(bus.btn_level), int'(e.lvl));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int p;
    int s0;
    int seq[4];
    cyc = 0;
    n_cmp = 0;
    n_bad = 0;
    press_seen = 0;
    exp_cnt = 0;
    rst = 1'b1;
    bus.btn_in = 1'b0;

    // reset with button held, then first press after release of reset
    wait_to(2);
    bus.btn_in = 1'b1;
    wait_to(3);
    rst = 1'b0;
    chk("rst_level", int'(bus.btn_level), 0);
    chk("rst_press", int'(bus.press_pulse), 0);
    chk("rst_release", int'(bus.release_pulse), 0);
    chk("rst_count", int'(bus.press_count), 0);
    p = cyc + LAT;
    exp_cnt = 1;
    push(1'b0, p, exp_cnt, 1'b1);
`ifdef BTN_AUTO_REPEAT_EN
    for (int k = 10; k <= 30; k += 5) begin
      exp_cnt++;
      push(1'b0, p + k, exp_cnt, 1'b1);
    end
`endif
    wait_to(p + 30);
    chk("hold_count", int'(bus.press_count), exp_cnt);
    bus.btn_in = 1'b0;
    push(1'b1, p + 30 + LAT, exp_cnt, 1'b0);
    wait_to(p + 30 + LAT);

    // bounce 1,0,1,0 then settle high
    t = cyc;
    seq = '{1, 0, 1, 0};
    for (int i = 0; i < 4; i++) begin
      wait_to(t + i);
      bus.btn_in = seq[i][0];
    end
    wait_to(t + 4);
    bus.btn_in = 1'b1;
    exp_cnt++;
    push(1'b0, t + 4 + LAT, exp_cnt, 1'b1);
    wait_to(t + 4 + LAT);
    bus.btn_in = 1'b0;
    push(1'b1, t + 4 + 2 * LAT, exp_cnt, 1'b0);
    wait_to(t + 4 + 2 * LAT);

    // short high glitch of 3 cycles
    t = cyc;
    bus.btn_in = 1'b1;
    wait_to(t + 3);
    bus.btn_in = 1'b0;
    wait_to(t + 12);
    chk("short_level", int'(bus.btn_level), 0);
    chk("short_count", int'(bus.press_count), exp_cnt);

    // 2-cycle low glitch while held, then a real release
    t = cyc;
    bus.btn_in = 1'b1;
    p = t + LAT;
    exp_cnt++;
    push(1'b0, p, exp_cnt, 1'b1);
    wait_to(p + 1);
    bus.btn_in = 1'b0;
    wait_to(p + 3);
    bus.btn_in = 1'b1;
    wait_to(p + 7);
    chk("glitch_level", int'(bus.btn_level), 1);
    bus.btn_in = 1'b0;
    push(1'b1, p + 7 + LAT, exp_cnt, 1'b0);
    wait_to(p + 7 + LAT);
    wait_to(cyc + 1);

    // counter wrap over 256 presses from a fresh reset
    rst = 1'b1;
    wait_to(cyc + 2);
    rst = 1'b0;
    exp_cnt = 0;
    chk("wrap_start", int'(bus.press_count), 0);
    s0 = press_seen;
    repeat (256) do_press();
    chk("wrap_count", int'(bus.press_count), 0);
    chk("wrap_strobes", press_seen - s0, 256);

    // reset asserted in the middle of ARM_PRESS
    do_press();
    t = cyc;
    bus.btn_in = 1'b1;
    wait_to(t + 4);
    rst = 1'b1;
    #1;
    chk("midrst_level", int'(bus.btn_level), 0);
    chk("midrst_press", int'(bus.press_pulse), 0);
    chk("midrst_count", int'(bus.press_count), 0);
    bus.btn_in = 1'b0;
    wait_to(cyc + 2);
    rst = 1'b0;
    exp_cnt = 0;
    wait_to(cyc + 12);
    chk("postrst_level", int'(bus.btn_level), 0);
    chk("postrst_count", int'(bus.press_count), 0);

    wait_to(cyc + 2);
    chk("queue_left", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
